// File: rtl/frame_buf_bram_pkg.sv
// Shared definitions for the frame buffer: clear-engine state encoding and
// the default 320x240, 12-bit pixel frame geometry.
package frame_buf_bram_pkg;

  localparam int FRAME_W     = 320;
  localparam int FRAME_H     = 240;
  localparam int FRAME_DEPTH = FRAME_W * FRAME_H;
  localparam int PIXEL_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/frame_buf_mem.sv
// Bare single-clock simple dual-port array: synchronous write, registered read,
// no reset, so synthesis maps it onto block RAM.
module frame_buf_mem #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 76800,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read samples the array before this edge's write lands: read-old-data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_buf_bram.sv
// Frame buffer: write port A, pipelined read port B, and a clear engine that
// fills the whole array with CLEAR_VAL on request or on reset release.
module frame_buf_bram
  import frame_buf_bram_pkg::*;
#(
  parameter int                DATA_W         = PIXEL_W,
  parameter int                DEPTH          = FRAME_DEPTH,
  parameter int                ADDR_W         = 17,
  parameter int                OUT_REG        = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL      = '0,
  parameter int                CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_ready,
  input  logic              b_rd,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_dout,
  output logic              b_valid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int                MEM_AW  = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_q, init_d;
  logic              a_ready_q, a_ready_d;

  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              a_in_range, b_in_range;
  logic              v1_q, v1_d, oor1_q, oor1_d;
  logic [DATA_W-1:0] rd_word;
  logic              pre_valid;
  logic [DATA_W-1:0] pre_data;
  logic              b_valid_q, b_valid_d;
  logic [DATA_W-1:0] b_dout_q, b_dout_d;

  assign a_in_range = {1'b0, a_addr} < DEPTH_V;
  assign b_in_range = {1'b0, b_addr} < DEPTH_V;

  // init_q marks the first cycle after reset release, used for the auto-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      init_q    <= 1'b1;
      a_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_q    <= init_d;
      a_ready_q <= a_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start || ((CLEAR_ON_RESET != 0) && init_q)) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Registered so that a_ready stays low through reset and the auto-clear.
    a_ready_d = (state_d == ST_IDLE);
  end

  always_comb begin
    clr_busy  = (state_q == ST_CLEAR);
    clr_done  = (state_q == ST_DONE);
    mem_we    = a_wr && a_ready_q && a_in_range;
    mem_waddr = a_addr[MEM_AW-1:0];
    mem_wdata = a_din;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q[MEM_AW-1:0];
      mem_wdata = CLEAR_VAL;
    end
  end

  assign a_ready = a_ready_q;

  frame_buf_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(MEM_AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (b_rd),
    .raddr(b_addr[MEM_AW-1:0]),
    .rdata(mem_rdata)
  );

  // Read pipeline: RAM register, optional extra stage, then the output hold register.
  always_comb begin
    v1_d   = b_rd;
    oor1_d = !b_in_range;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q   <= 1'b0;
      oor1_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      oor1_q <= oor1_d;
    end
  end

  assign rd_word = oor1_q ? '0 : mem_rdata;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              v2_q, v2_d;
      logic [DATA_W-1:0] d2_q, d2_d;

      always_comb begin
        v2_d = v1_q;
        d2_d = rd_word;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v2_q <= 1'b0;
          d2_q <= '0;
        end else begin
          v2_q <= v2_d;
          d2_q <= d2_d;
        end
      end

      assign pre_valid = v2_q;
      assign pre_data  = d2_q;
    end else begin : g_no_out_reg
      assign pre_valid = v1_q;
      assign pre_data  = rd_word;
    end
  endgenerate

  always_comb begin
    b_valid_d = pre_valid;
    b_dout_d  = pre_valid ? pre_data : b_dout_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_valid_q <= 1'b0;
      b_dout_q  <= '0;
    end else begin
      b_valid_q <= b_valid_d;
      b_dout_q  <= b_dout_d;
    end
  end

  assign b_valid = b_valid_q;
  assign b_dout  = b_dout_q;

endmodule

// File: tb/tb_frame_buf_bram.sv
// Directed bench: full-size frame buffer for the data path, 16-word instances
// for the clear engine, mid-clear reset and auto-clear on reset release.
module tb_frame_buf_bram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // x_*: DEPTH=76800, no auto-clear
  logic        x_wr = 0, x_rd = 0, x_start = 0;
  logic [16:0] x_waddr = 0, x_raddr = 0;
  logic [11:0] x_din = 0, x_dout;
  logic        x_ready, x_valid, x_busy, x_done;
  // y_*: DEPTH=16, CLEAR_VAL=12'h5A5, no auto-clear
  logic        y_wr = 0, y_rd = 0, y_start = 0;
  logic [4:0]  y_waddr = 0, y_raddr = 0;
  logic [11:0] y_din = 0, y_dout;
  logic        y_ready, y_valid, y_busy, y_done;
  // z_*: DEPTH=16, auto-clear on reset release
  logic        z_ready, z_valid, z_busy, z_done;
  logic [11:0] z_dout;
  logic        z_zero = 1'b0;
  logic [4:0]  z_addr = 5'd0;
  logic [11:0] z_din = 12'd0;

  frame_buf_bram #(.CLEAR_ON_RESET(0)) dut_x (
    .clk(clk), .reset(rst),
    .a_wr(x_wr), .a_addr(x_waddr), .a_din(x_din), .a_ready(x_ready),
    .b_rd(x_rd), .b_addr(x_raddr), .b_dout(x_dout), .b_valid(x_valid),
    .clr_start(x_start), .clr_busy(x_busy), .clr_done(x_done)
  );

  frame_buf_bram #(.DEPTH(16), .ADDR_W(5), .CLEAR_VAL(12'h5A5), .CLEAR_ON_RESET(0)) dut_y (
    .clk(clk), .reset(rst),
    .a_wr(y_wr), .a_addr(y_waddr), .a_din(y_din), .a_ready(y_ready),
    .b_rd(y_rd), .b_addr(y_raddr), .b_dout(y_dout), .b_valid(y_valid),
    .clr_start(y_start), .clr_busy(y_busy), .clr_done(y_done)
  );

  frame_buf_bram #(.DEPTH(16), .ADDR_W(5), .CLEAR_ON_RESET(1)) dut_z (
    .clk(clk), .reset(rst),
    .a_wr(z_zero), .a_addr(z_addr), .a_din(z_din), .a_ready(z_ready),
    .b_rd(z_zero), .b_addr(z_addr), .b_dout(z_dout), .b_valid(z_valid),
    .clr_start(z_zero), .clr_busy(z_busy), .clr_done(z_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic x_write(input logic [16:0] a, input logic [11:0] d);
    x_wr = 1'b1; x_waddr = a; x_din = d;
    tick();
    x_wr = 1'b0;
  endtask

  task automatic y_write(input logic [4:0] a, input logic [11:0] d);
    y_wr = 1'b1; y_waddr = a; y_din = d;
    tick();
    y_wr = 1'b0;
  endtask

  // Pipelined read of all 16 words of dut_y against exp_mem.
  logic [11:0] exp_mem [16];
  task automatic y_read_all(input string tag);
    for (int i = 0; i < 18; i++) begin
      y_rd = (i < 16);
      y_raddr = 5'(i);
      tick();
      if (i >= 2) begin
        chk($sformatf("%s_valid%0d", tag, i - 2), y_valid, 1);
        chk($sformatf("%s_word%0d", tag, i - 2), y_dout, exp_mem[i - 2]);
      end
    end
    y_rd = 1'b0;
  endtask

  initial begin
    int busy_n, done_n, viol_n, vpulse_n;

    // Reset state
    repeat (3) tick();
    chk("rst_a_ready", x_ready, 0);
    chk("rst_b_valid", x_valid, 0);
    chk("rst_b_dout", x_dout, 0);
    chk("rst_clr_busy", x_busy, 0);
    chk("rst_clr_done", x_done, 0);
    chk("rst_z_ready", z_ready, 0);
    rst = 1'b0;
    tick();
    chk("rel_x_ready", x_ready, 1);
    chk("rel_y_ready", y_ready, 1);
    chk("rel_z_ready", z_ready, 0);
    chk("rel_z_busy", z_busy, 1);

    // Auto-clear after reset release on dut_z
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (z_busy) busy_n++;
      if (z_done) done_n++;
      tick();
    end
    chk("auto_busy_cycles", busy_n, 16);
    chk("auto_done_pulses", done_n, 1);
    chk("auto_ready_after", z_ready, 1);

    // Write then read with two-cycle latency
    x_write(17'd5, 12'hABC);
    x_rd = 1'b1; x_raddr = 17'd5;
    tick();
    x_rd = 1'b0;
    chk("lat_n0_valid", x_valid, 0);
    tick();
    chk("lat_n1_valid", x_valid, 0);
    tick();
    chk("lat_n2_valid", x_valid, 1);
    chk("lat_n2_data", x_dout, 12'hABC);
    tick();
    chk("lat_n3_valid", x_valid, 0);
    chk("hold_data", x_dout, 12'hABC);

    // Back-to-back reads
    x_write(17'd0, 12'h111);
    x_write(17'd1, 12'h222);
    x_write(17'd2, 12'h333);
    x_rd = 1'b1;
    x_raddr = 17'd0; tick();
    x_raddr = 17'd1; tick();
    x_raddr = 17'd2; tick();
    x_rd = 1'b0;
    chk("b2b_v0", x_valid, 1); chk("b2b_d0", x_dout, 12'h111);
    tick();
    chk("b2b_v1", x_valid, 1); chk("b2b_d1", x_dout, 12'h222);
    tick();
    chk("b2b_v2", x_valid, 1); chk("b2b_d2", x_dout, 12'h333);
    tick();
    chk("b2b_v3", x_valid, 0);

    // Same-cycle read and write returns old data
    x_write(17'd7, 12'h0F0);
    x_wr = 1'b1; x_waddr = 17'd7; x_din = 12'h123;
    x_rd = 1'b1; x_raddr = 17'd7;
    tick();
    x_wr = 1'b0; x_rd = 1'b0;
    tick(); tick();
    chk("rw_old_valid", x_valid, 1);
    chk("rw_old_data", x_dout, 12'h0F0);
    x_rd = 1'b1; x_raddr = 17'd7;
    tick();
    x_rd = 1'b0;
    tick(); tick();
    chk("rw_new_data", x_dout, 12'h123);

    // Out-of-range write and read
    x_write(17'd76799, 12'h777);
    x_write(17'd76800, 12'hFFF);
    x_rd = 1'b1; x_raddr = 17'd76800;
    tick();
    x_raddr = 17'd76799;
    tick();
    x_rd = 1'b0;
    tick();
    chk("oor_valid", x_valid, 1);
    chk("oor_data", x_dout, 12'h000);
    tick();
    chk("last_valid", x_valid, 1);
    chk("last_data", x_dout, 12'h777);

    // Full clear on 16-word instance, with writes and a restart attempt during it
    for (int i = 0; i < 16; i++) y_write(5'(i), 12'h300 + 12'(i));
    y_start = 1'b1;
    tick();
    y_start = 1'b0;
    y_wr = 1'b1; y_waddr = 5'd4; y_din = 12'hBAD;
    busy_n = 0; done_n = 0; viol_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (y_busy) busy_n++;
      if ((y_busy || y_done) && y_ready) viol_n++;
      if (y_done) begin
        done_n++;
        y_wr = 1'b0;
      end
      y_start = (i == 5);
      tick();
    end
    y_wr = 1'b0; y_start = 1'b0;
    chk("clr_busy_cycles", busy_n, 16);
    chk("clr_done_pulses", done_n, 1);
    chk("clr_ready_low", viol_n, 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 12'h5A5;
    y_read_all("clr");

    // Reset at counter 8 aborts the clear, drops the in-flight read
    for (int i = 0; i < 16; i++) y_write(5'(i), 12'h0C0 + 12'(i));
    y_start = 1'b1;
    tick();
    y_start = 1'b0;
    chk("abort_busy_start", y_busy, 1);
    repeat (7) tick();
    y_rd = 1'b1; y_raddr = 5'd0;
    tick();
    y_rd = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", y_busy, 0);
    chk("abort_done", y_done, 0);
    chk("abort_ready", y_ready, 0);
    chk("abort_valid", y_valid, 0);
    chk("abort_dout", y_dout, 0);
    tick(); tick();
    rst = 1'b0;
    done_n = 0; vpulse_n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (y_done) done_n++;
      if (y_valid) vpulse_n++;
    end
    chk("abort_no_done", done_n, 0);
    chk("abort_no_valid", vpulse_n, 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = (i < 8) ? 12'h5A5 : 12'h0C0 + 12'(i);
    y_read_all("part");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
